// File: rtl/down_timer.sv
`default_nettype none
// ============================================================================
//  Module   : down_timer
//  Purpose  : BCD countdown timer (SS.hh) with IDLE/RUN/PAUSED/EXPIRED
//             control, decremented by a 100 Hz tick strobe. All outputs are
//             registered.
//  Revision : 1.0 - initial release
// ============================================================================
module down_timer #(
  parameter bit CLAMP_BCD = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] count,
  output logic        running,
  output logic        done,
  output logic        expired
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  localparam logic [15:0] COUNT_ZERO = 16'h0000;
  localparam logic [15:0] COUNT_ONE  = 16'h0001;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [15:0] count_next;
  logic [15:0] load_clamped;
  logic [15:0] count_dec;
  logic        expire_event;
  logic        running_next;
  logic        done_next;
  logic        expired_next;

  // Only an exclusive start or an exclusive pause is a valid command;
  // both together is treated as no command at all.
  logic start_cmd;
  logic pause_cmd;
  assign start_cmd = start & ~pause;
  assign pause_cmd = pause & ~start;

  // Per-digit conditioning of the preset: saturate non-BCD digits to 9
  // when clamping is enabled, otherwise pass the nibble through.
  for (genvar g = 0; g < 4; g++) begin : g_digit
    if (CLAMP_BCD) begin : g_clamp
      assign load_clamped[g*4 +: 4] =
        (load_value[g*4 +: 4] > 4'd9) ? 4'd9 : load_value[g*4 +: 4];
    end else begin : g_raw
      assign load_clamped[g*4 +: 4] = load_value[g*4 +: 4];
    end
  end

  // BCD borrow chain: a zero digit wraps to 9 and passes the borrow upward.
  function automatic logic [15:0] bcd_dec(input logic [15:0] value);
    logic [15:0] result;
    logic        borrow;
    logic [3:0]  digit;
    result = value;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      digit = value[i*4 +: 4];
      if (borrow) begin
        if (digit == 4'd0) begin
          result[i*4 +: 4] = 4'd9;
        end else begin
          result[i*4 +: 4] = digit - 4'd1;
          borrow           = 1'b0;
        end
      end
    end
    return result;
  endfunction

  assign count_dec = bcd_dec(count);

  // State register plus registered count and status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      count   <= COUNT_ZERO;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      running <= running_next;
      done    <= done_next;
      expired <= expired_next;
    end
  end

  // Next-state and next-count: load wins, then start/pause, then tick.
  always_comb begin
    state_next   = state;
    count_next   = count;
    expire_event = 1'b0;
    if (load) begin
      state_next = ST_IDLE;
      count_next = load_clamped;
    end else begin
      case (state)
        ST_IDLE: begin
          // A zero preset cannot be started; it would expire immediately.
          if (start_cmd && (count != COUNT_ZERO)) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause_cmd) begin
            state_next = ST_PAUSED;
          end else if (tick && !pause) begin
            if (count == COUNT_ONE) begin
              state_next   = ST_EXPIRED;
              count_next   = COUNT_ZERO;
              expire_event = 1'b1;
            end else begin
              count_next = count_dec;
            end
          end
        end
        ST_PAUSED: begin
          // Resuming never decrements on the resume edge itself.
          if (start_cmd) begin
            state_next = ST_RUN;
          end
        end
        ST_EXPIRED: begin
          count_next = COUNT_ZERO;
        end
        default: begin
          state_next = ST_IDLE;
          count_next = COUNT_ZERO;
        end
      endcase
    end
  end

  // Status flags derived from the upcoming state, registered above.
  always_comb begin
    running_next = (state_next == ST_RUN);
    expired_next = (state_next == ST_EXPIRED);
    done_next    = expire_event;
  end

endmodule
`default_nettype wire

// File: tb/tb_down_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_down_timer
//  Purpose  : Directed self-checking bench for down_timer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_down_timer;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        load;
  logic [15:0] load_value;
  logic        start;
  logic        pause;
  logic [15:0] count;
  logic        running;
  logic        done;
  logic        expired;

  int total;
  int bad;

  // Observed bundle: {count, running, done, expired}
  logic [18:0] obs;
  assign obs = {count, running, done, expired};

  down_timer #(.CLAMP_BCD(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .count      (count),
    .running    (running),
    .done       (done),
    .expired    (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_value = v;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; load = 1'b1; load_value = 16'h1234; start = 1'b1; tick = 1'b1;
    step();
    total++;
    if (obs !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_state: got %h want %h", obs, {16'h0000, 3'b000});
    end
    reset = 1'b1; load = 1'b0; start = 1'b0; tick = 1'b0;
    step();
    total++;
    if (obs !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_release: got %h want %h", obs, {16'h0000, 3'b000});
    end
  endtask

  task automatic test_expiry();
    do_load(16'h0003);
    do_start();
    total++;
    if (obs !== {16'h0003, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL exp_start: got %h want %h", obs, {16'h0003, 3'b100});
    end
    do_tick();
    total++;
    if (obs !== {16'h0002, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL exp_tick1: got %h want %h", obs, {16'h0002, 3'b100});
    end
    do_tick();
    total++;
    if (obs !== {16'h0001, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL exp_tick2: got %h want %h", obs, {16'h0001, 3'b100});
    end
    do_tick();
    total++;
    if (obs !== {16'h0000, 1'b0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL exp_tick3_done: got %h want %h", obs, {16'h0000, 3'b011});
    end
    step();
    total++;
    if (obs !== {16'h0000, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL exp_done_drop: got %h want %h", obs, {16'h0000, 3'b001});
    end
    start = 1'b1; tick = 1'b1;
    step(); step();
    start = 1'b0; tick = 1'b0;
    total++;
    if (obs !== {16'h0000, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL exp_hold: got %h want %h", obs, {16'h0000, 3'b001});
    end
  endtask

  task automatic test_borrow();
    do_load(16'h0100);
    total++;
    if (obs !== {16'h0100, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL brw_load_clears_exp: got %h want %h", obs, {16'h0100, 3'b000});
    end
    do_start();
    do_tick();
    total++;
    if (obs !== {16'h0099, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL brw_0100: got %h want %h", obs, {16'h0099, 3'b100});
    end
    do_load(16'h1000);
    do_start();
    do_tick();
    total++;
    if (obs !== {16'h0999, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL brw_1000: got %h want %h", obs, {16'h0999, 3'b100});
    end
  endtask

  task automatic test_pause();
    do_load(16'h0500);
    do_start();
    for (int i = 0; i < 10; i++) do_tick();
    total++;
    if (obs !== {16'h0490, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL pse_10ticks: got %h want %h", obs, {16'h0490, 3'b100});
    end
    // pause edge with tick high: tick ignored
    pause = 1'b1; tick = 1'b1;
    step();
    pause = 1'b0; tick = 1'b0;
    total++;
    if (obs !== {16'h0490, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL pse_enter: got %h want %h", obs, {16'h0490, 3'b000});
    end
    for (int i = 0; i < 5; i++) do_tick();
    total++;
    if (obs !== {16'h0490, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL pse_hold: got %h want %h", obs, {16'h0490, 3'b000});
    end
    do_start();
    total++;
    if (obs !== {16'h0490, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL pse_resume: got %h want %h", obs, {16'h0490, 3'b100});
    end
    do_tick();
    total++;
    if (obs !== {16'h0489, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL pse_final_tick: got %h want %h", obs, {16'h0489, 3'b100});
    end
  endtask

  task automatic test_clamp();
    do_load(16'hFA2C);
    total++;
    if (obs !== {16'h9929, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL clmp_load: got %h want %h", obs, {16'h9929, 3'b000});
    end
    start = 1'b1; pause = 1'b1;
    step();
    total++;
    if (obs !== {16'h9929, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL clmp_both_idle: got %h want %h", obs, {16'h9929, 3'b000});
    end
    start = 1'b0; pause = 1'b0;
    do_start();
    start = 1'b1; pause = 1'b1;
    step();
    start = 1'b0; pause = 1'b0;
    total++;
    if (obs !== {16'h9929, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL clmp_both_run: got %h want %h", obs, {16'h9929, 3'b100});
    end
  endtask

  task automatic test_tick_edges();
    do_load(16'h0050);
    start = 1'b1; tick = 1'b1;
    step();
    start = 1'b0; tick = 1'b0;
    total++;
    if (obs !== {16'h0050, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL edge_start_tick: got %h want %h", obs, {16'h0050, 3'b100});
    end
    load = 1'b1; load_value = 16'h0077; tick = 1'b1;
    step();
    load = 1'b0; tick = 1'b0;
    total++;
    if (obs !== {16'h0077, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL edge_load_tick: got %h want %h", obs, {16'h0077, 3'b000});
    end
    do_load(16'h0000);
    do_start();
    total++;
    if (obs !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL edge_start_zero: got %h want %h", obs, {16'h0000, 3'b000});
    end
  endtask

  task automatic test_reset_mid_run();
    do_load(16'h0045);
    do_start();
    for (int i = 0; i < 3; i++) do_tick();
    total++;
    if (obs !== {16'h0042, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL rmr_pre: got %h want %h", obs, {16'h0042, 3'b100});
    end
    reset = 1'b0; tick = 1'b1;
    step();
    reset = 1'b1; tick = 1'b0;
    total++;
    if (obs !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL rmr_reset: got %h want %h", obs, {16'h0000, 3'b000});
    end
    do_start();
    total++;
    if (obs !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL rmr_start_ignored: got %h want %h", obs, {16'h0000, 3'b000});
    end
    do_tick();
    total++;
    if (obs !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL rmr_tick_ignored: got %h want %h", obs, {16'h0000, 3'b000});
    end
    // Reset while expired: flags clear, no done
    do_load(16'h0001);
    do_start();
    do_tick();
    total++;
    if (obs !== {16'h0000, 1'b0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL rex_expire: got %h want %h", obs, {16'h0000, 3'b011});
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    total++;
    if (obs !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL rex_reset: got %h want %h", obs, {16'h0000, 3'b000});
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; tick = 1'b0; load = 1'b0; load_value = 16'h0000;
    start = 1'b0; pause = 1'b0;
    #2;
    test_reset();
    test_expiry();
    test_borrow();
    test_pause();
    test_clamp();
    test_tick_edges();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 Parameter CLAMP_BCD, default 1: when 1, any loaded BCD digit above 9 SHALL be stored as 9; when 0, the digit SHALL be stored unmodified.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 tick  input  1  one-cycle enable pulse at 100 Hz from the clock divider; it is the decrement strobe.
REQ-005 load  input  1  load request; sampled on each rising edge.
REQ-006 load_value  input  16  BCD preset: [15:12] seconds tens, [11:8] seconds ones, [7:4] hundredths tens, [3:0] hundredths ones.
REQ-007 start  input  1  run request; level-sampled.
REQ-008 pause  input  1  pause request; level-sampled.
REQ-009 count  output  16  current remaining time in the load_value BCD format; registered.
REQ-010 running  output  1  high while the state is RUN; registered.
REQ-011 done  output  1  one-cycle pulse on expiry; registered.
REQ-012 expired  output  1  high while the state is EXPIRED; registered.

Function
REQ-013 The block SHALL implement four states: IDLE, RUN, PAUSED and EXPIRED.
REQ-014 Input priority SHALL be: reset, then load, then start/pause, then tick.
REQ-015 A load in any state SHALL, on that edge, set count to load_value (clamped per REQ-001), move to IDLE, clear expired and suppress tick.
REQ-016 IDLE: start=1, pause=0 and count≠0 SHALL move to RUN; start with count=0 SHALL be ignored (stay IDLE, no done).
REQ-017 RUN: pause=1, start=0 SHALL move to PAUSED with count held; tick is ignored on that edge.
REQ-018 PAUSED: start=1, pause=0 SHALL move to RUN.
REQ-019 start=1 and pause=1 in the same cycle SHALL be ignored in every state.
REQ-020 Only in RUN, with no load or pause, a tick SHALL decrement count by one hundredth on that edge.
REQ-021 Decrement SHALL use a BCD borrow chain: a digit at 0 becomes 9 and borrows from the next digit. Seconds tens SHALL also decrement 0→9 when borrowed into, though this never occurs because count=0 is caught by REQ-022.
REQ-022 A tick in RUN with count=0001 SHALL, on the same edge, set count=0000, enter EXPIRED and assert done for exactly one cycle.
REQ-023 The entry edge into RUN SHALL NOT decrement even if tick is high; the first decrement is on the next tick.
REQ-024 EXPIRED SHALL hold count=0000 and expired=1 and ignore start, pause and tick until load or reset.
REQ-025 done SHALL be 0 in every cycle other than the one following the expiry edge.
REQ-026 Outputs SHALL be purely registered; there is no combinational input-to-output path.
REQ-027 Latency: count SHALL reflect a tick one clock after the tick is sampled.

Reset
REQ-028 While reset=0 at a rising edge, the block SHALL set state=IDLE, count=0000, running=0, done=0 and expired=0, overriding all other inputs.
REQ-029 Reset asserted mid-RUN or in EXPIRED SHALL take effect on the next edge with no done pulse; after release, a start SHALL be ignored until a load.

Verification
REQ-030 Load 0x0003, start, then 3 ticks -> count 0002, 0001, 0000; done high exactly one cycle after the third tick; expired=1, running=0.
REQ-031 Load 0x0100, start, 1 tick -> count 0099 (borrow across the digits); load 0x1000, start, 1 tick -> count 0999.
REQ-032 Load 0x0500, start, 10 ticks, pause, 5 ticks, start, 1 tick -> count 0490 during the pause, 0489 after the final tick.
REQ-033 Load 0xFA2C with CLAMP_BCD=1 -> count 0x9929; start and pause asserted together -> state unchanged.
REQ-034 Start with tick high on the same edge -> no decrement; load with tick high in RUN -> count=load_value, state IDLE.
REQ-035 In RUN at count 0042, drive reset=0 for one cycle -> count 0000, all flags 0, no done; start afterwards is ignored.
